// File: rtl/instruction_fetch_controller.sv
// Fetch sequencer: reads program memory at the current PC, hands the instruction to
// decode with valid/ready, and strobes o_wrPC with a clean low-high-low pulse to advance.
module instruction_fetch_controller #(
  parameter int                     PC_CANT_BITS = 11,
  parameter int                     INSTR_BITS   = 16,
  parameter int                     OPCODE_BITS  = 5,
  parameter logic [OPCODE_BITS-1:0] HALT_OPCODE  = '0
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_step_mode,
  input  logic                    i_step,
  input  logic [PC_CANT_BITS-1:0] i_addr,
  output logic [PC_CANT_BITS-1:0] o_mem_addr,
  output logic                    o_mem_rd_en,
  input  logic [INSTR_BITS-1:0]   i_mem_data,
  output logic [INSTR_BITS-1:0]   o_instr,
  output logic                    o_instr_valid,
  input  logic                    i_instr_ready,
  output logic                    o_wrPC,
  output logic                    o_halted,
  output logic [PC_CANT_BITS-1:0] o_fetch_count
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    PRESENT,
    ADVANCE,
    RELEASE,
    PAUSE,
    HALTED
  } state_t;

  state_t state;
  state_t state_next;
  logic   step_prev;
  logic   step_rise;
  logic   accept;
  logic   is_halt;

  assign o_mem_addr = i_addr;
  assign step_rise  = i_step & ~step_prev;
  assign accept     = (state == PRESENT) & i_instr_ready;
  assign is_halt    = (o_instr[INSTR_BITS-1 -: OPCODE_BITS] == HALT_OPCODE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = READ;
      READ:    state_next = WAIT;
      WAIT:    state_next = PRESENT;
      PRESENT: if (i_instr_ready) state_next = is_halt ? HALTED : ADVANCE;
      ADVANCE: state_next = RELEASE;
      RELEASE: state_next = i_step_mode ? PAUSE : READ;
      PAUSE:   if (step_rise) state_next = READ;
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is high exactly in its own state.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state         <= IDLE;
      step_prev     <= 1'b0;
      o_mem_rd_en   <= 1'b0;
      o_instr_valid <= 1'b0;
      o_wrPC        <= 1'b0;
      o_halted      <= 1'b0;
      o_instr       <= '0;
      o_fetch_count <= '0;
    end else begin
      state         <= state_next;
      step_prev     <= i_step;
      o_mem_rd_en   <= (state_next == READ);
      o_instr_valid <= (state_next == PRESENT);
      o_wrPC        <= (state_next == ADVANCE);
      o_halted      <= (state_next == HALTED);
      if (state == WAIT) o_instr <= i_mem_data;
      if (accept) o_fetch_count <= o_fetch_count + PC_CANT_BITS'(1);
    end
  end

endmodule
